// File: rtl/startup_sequencer_pkg.sv
// Shared definitions for the startup sequencer: state encoding and datapath widths.
package startup_sequencer_pkg;

   localparam int unsigned StateW = 3;   // width of the debug state output
   localparam int unsigned TickW  = 8;   // splash tick counter width
   localparam int unsigned CycW   = 32;  // shared cycle counter width

   // Encoding is visible on seq_state, so values are pinned explicitly.
   typedef enum logic [StateW-1:0] {
      StSplash = 3'd0,
      StSysRst = 3'd1,
      StCpuDly = 3'd2,
      StPeriph = 3'd3,
      StRun    = 3'd4
   } seq_state_e;

endpackage

// File: rtl/startup_sequencer_seq_timer.sv
// seq_timer: 32-bit cycle counter with synchronous clear, count enable and a terminal-count
// flag. One instance is shared by every timed state of the sequencer; the terminal value is
// selected by the caller through limit_i.
//  clk_i    in   clock, rising edge
//  rst_i    in   synchronous active-high reset
//  clr_i    in   clear counter to 0 at the next edge (wins over en_i)
//  en_i     in   increment at the next edge
//  limit_i  in   cycles per period; tc_o marks count == limit_i-1 (limit_i >= 1)
//  tc_o     out  terminal-count flag, combinational from the current count
module seq_timer
   import startup_sequencer_pkg::*;
(
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            clr_i,
   input  logic            en_i,
   input  logic [CycW-1:0] limit_i,
   output logic            tc_o
);

   logic [CycW-1:0] cnt_d, cnt_q;

   // The owner clears on the terminal edge, so the counter never runs past limit_i-1.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i) begin
         cnt_d = cnt_q + CycW'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tc_o = (cnt_q == (limit_i - CycW'(1)));

endmodule

// File: rtl/startup_sequencer.sv
// startup_sequencer: power-on / soft-reset sequencer. Walks SPLASH -> SYS_RST -> CPU_DLY ->
// PERIPH -> RUN, releasing the chipset reset, the CPU reset and then each peripheral reset
// in bit order. All outputs are registered and reflect the new state on the transition edge.
//  clk_chipset     in   sole clock, rising edge
//  reset           in   synchronous active-high reset, overrides everything
//  splash_skip     in   level; ends the splash at the next edge
//  soft_reset_req  in   restarts at SYS_RST from any state except SPLASH
//  cpu_hold        in   level; freezes the CPU_DLY count
//  splashscreen    out  1 while in SPLASH
//  reset_sys       out  chipset reset, active-high
//  reset_cpu       out  CPU reset, active-high
//  reset_periph    out  peripheral resets, active-high; bit 0 released first
//  seq_done        out  1 in RUN
//  seq_state       out  current state encoding (debug)
module startup_sequencer
   import startup_sequencer_pkg::*;
#(
   parameter int unsigned SPLASH_TICK_CYCLES = 28636000,
   parameter int unsigned SPLASH_TICKS       = 5,
   parameter int unsigned SYS_RESET_CYCLES   = 65535,
   parameter int unsigned CPU_RESET_CYCLES   = 42,
   parameter int unsigned NUM_PERIPH         = 2,
   parameter int unsigned PERIPH_GAP         = 16
) (
   input  logic                  clk_chipset,
   input  logic                  reset,
   input  logic                  splash_skip,
   input  logic                  soft_reset_req,
   input  logic                  cpu_hold,
   output logic                  splashscreen,
   output logic                  reset_sys,
   output logic                  reset_cpu,
   output logic [NUM_PERIPH-1:0] reset_periph,
   output logic                  seq_done,
   output logic [StateW-1:0]     seq_state
);

   localparam int unsigned IdxW = (NUM_PERIPH > 1) ? $clog2(NUM_PERIPH) : 1;

   seq_state_e            state_d, state_q;
   logic [TickW-1:0]      tick_d, tick_q;
   logic [IdxW-1:0]       periph_idx_d, periph_idx_q;
   // Low for the first edge after reset so that edge counts as SPLASH entry.
   logic                  armed_d, armed_q;

   logic                  tmr_clr, tmr_en, tmr_tc;
   logic [CycW-1:0]       tmr_limit;
   logic                  clear_bit;

   logic                  splashscreen_d, splashscreen_q;
   logic                  reset_sys_d, reset_sys_q;
   logic                  reset_cpu_d, reset_cpu_q;
   logic [NUM_PERIPH-1:0] reset_periph_d, reset_periph_q;
   logic                  seq_done_d, seq_done_q;

   // Terminal value for the shared timer depends on which state is being timed.
   always_comb begin
      unique case (state_q)
         StSplash: tmr_limit = CycW'(SPLASH_TICK_CYCLES);
         StSysRst: tmr_limit = CycW'(SYS_RESET_CYCLES);
         StCpuDly: tmr_limit = CycW'(CPU_RESET_CYCLES);
         StPeriph: tmr_limit = CycW'(PERIPH_GAP);
         default:  tmr_limit = CycW'(1);
      endcase
   end

   seq_timer u_seq_timer (
      .clk_i   (clk_chipset),
      .rst_i   (reset),
      .clr_i   (tmr_clr),
      .en_i    (tmr_en),
      .limit_i (tmr_limit),
      .tc_o    (tmr_tc)
   );

   // Next-state logic.
   always_comb begin
      state_d      = state_q;
      tick_d       = tick_q;
      periph_idx_d = periph_idx_q;
      armed_d      = 1'b1;
      tmr_clr      = 1'b0;
      tmr_en       = 1'b0;
      clear_bit    = 1'b0;

      if (soft_reset_req && (state_q != StSplash)) begin
         // Held high, this keeps re-entering SYS_RST with the counter at 0.
         state_d      = StSysRst;
         tick_d       = '0;
         periph_idx_d = '0;
         tmr_clr      = 1'b1;
      end else begin
         unique case (state_q)
            StSplash: begin
               if (splash_skip || (armed_q && (SPLASH_TICKS == 0))) begin
                  state_d = StSysRst;
                  tick_d  = '0;
                  tmr_clr = 1'b1;
               end else if (armed_q) begin
                  if (tmr_tc) begin
                     tmr_clr = 1'b1;
                     if (tick_q == TickW'(SPLASH_TICKS - 1)) begin
                        state_d = StSysRst;
                        tick_d  = '0;
                     end else begin
                        tick_d = tick_q + TickW'(1);
                     end
                  end else begin
                     tmr_en = 1'b1;
                  end
               end
            end
            StSysRst: begin
               if (tmr_tc) begin
                  state_d = StCpuDly;
                  tmr_clr = 1'b1;
               end else begin
                  tmr_en = 1'b1;
               end
            end
            StCpuDly: begin
               // Hold is checked first so it also blocks the terminal edge.
               if (!cpu_hold) begin
                  if (tmr_tc) begin
                     state_d = StPeriph;
                     tmr_clr = 1'b1;
                  end else begin
                     tmr_en = 1'b1;
                  end
               end
            end
            StPeriph: begin
               if (tmr_tc) begin
                  tmr_clr   = 1'b1;
                  clear_bit = 1'b1;
                  if (periph_idx_q == IdxW'(NUM_PERIPH - 1)) begin
                     state_d = StRun;
                  end else begin
                     periph_idx_d = periph_idx_q + IdxW'(1);
                  end
               end else begin
                  tmr_en = 1'b1;
               end
            end
            StRun: begin
            end
            default: begin
               state_d = StSplash;
               tmr_clr = 1'b1;
            end
         endcase
      end
   end

   always_ff @(posedge clk_chipset) begin
      if (reset) begin
         state_q      <= StSplash;
         tick_q       <= '0;
         periph_idx_q <= '0;
         armed_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         tick_q       <= tick_d;
         periph_idx_q <= periph_idx_d;
         armed_q      <= armed_d;
      end
   end

   // Output values are derived from state_d so they change on the transition edge.
   always_comb begin
      splashscreen_d = (state_d == StSplash);
      reset_sys_d    = (state_d == StSplash) || (state_d == StSysRst);
      reset_cpu_d    = reset_sys_d || (state_d == StCpuDly);
      seq_done_d     = (state_d == StRun);
      reset_periph_d = reset_periph_q;
      if (reset_cpu_d) begin
         reset_periph_d = '1;
      end else begin
         for (int i = 0; i < NUM_PERIPH; i++) begin
            if (clear_bit && (periph_idx_q == IdxW'(i))) begin
               reset_periph_d[i] = 1'b0;
            end
         end
      end
   end

   always_ff @(posedge clk_chipset) begin
      if (reset) begin
         splashscreen_q <= 1'b1;
         reset_sys_q    <= 1'b1;
         reset_cpu_q    <= 1'b1;
         reset_periph_q <= '1;
         seq_done_q     <= 1'b0;
      end else begin
         splashscreen_q <= splashscreen_d;
         reset_sys_q    <= reset_sys_d;
         reset_cpu_q    <= reset_cpu_d;
         reset_periph_q <= reset_periph_d;
         seq_done_q     <= seq_done_d;
      end
   end

   assign splashscreen = splashscreen_q;
   assign reset_sys    = reset_sys_q;
   assign reset_cpu    = reset_cpu_q;
   assign reset_periph = reset_periph_q;
   assign seq_done     = seq_done_q;
   assign seq_state    = state_q;

endmodule

// File: tb/tb_startup_sequencer.sv
// Directed bench for startup_sequencer. Edge n counts rising edges after reset release
// (edge 0 is the first edge with reset=0); outputs are sampled 1 time unit after each edge.
module tb_startup_sequencer;

   logic       clk;
   logic       reset;
   logic       splash_skip;
   logic       soft_reset_req;
   logic       cpu_hold;
   logic       splashscreen;
   logic       reset_sys;
   logic       reset_cpu;
   logic [1:0] reset_periph;
   logic       seq_done;
   logic [2:0] seq_state;

   logic       c_splashscreen;
   logic       c_reset_sys;
   logic       c_reset_cpu;
   logic [0:0] c_reset_periph;
   logic       c_seq_done;
   logic [2:0] c_seq_state;

   int tests_run;
   int tests_failed;
   int e;

   startup_sequencer #(
      .SPLASH_TICK_CYCLES (4),
      .SPLASH_TICKS       (2),
      .SYS_RESET_CYCLES   (8),
      .CPU_RESET_CYCLES   (3),
      .NUM_PERIPH         (2),
      .PERIPH_GAP         (2)
   ) dut (
      .clk_chipset    (clk),
      .reset          (reset),
      .splash_skip    (splash_skip),
      .soft_reset_req (soft_reset_req),
      .cpu_hold       (cpu_hold),
      .splashscreen   (splashscreen),
      .reset_sys      (reset_sys),
      .reset_cpu      (reset_cpu),
      .reset_periph   (reset_periph),
      .seq_done       (seq_done),
      .seq_state      (seq_state)
   );

   startup_sequencer #(
      .SPLASH_TICK_CYCLES (4),
      .SPLASH_TICKS       (0),
      .SYS_RESET_CYCLES   (8),
      .CPU_RESET_CYCLES   (3),
      .NUM_PERIPH         (1),
      .PERIPH_GAP         (2)
   ) dut_c (
      .clk_chipset    (clk),
      .reset          (reset),
      .splash_skip    (1'b0),
      .soft_reset_req (1'b0),
      .cpu_hold       (1'b0),
      .splashscreen   (c_splashscreen),
      .reset_sys      (c_reset_sys),
      .reset_cpu      (c_reset_cpu),
      .reset_periph   (c_reset_periph),
      .seq_done       (c_seq_done),
      .seq_state      (c_seq_state)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Advance to just after edge n.
   task automatic goto(input int n);
      while (e < n) begin
         @(posedge clk);
         #1;
         e++;
      end
   endtask

   task automatic do_reset();
      reset          = 1'b1;
      splash_skip    = 1'b0;
      soft_reset_req = 1'b0;
      cpu_hold       = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      e     = -1;
   endtask

   task automatic test_reset();
      reset          = 1'b1;
      splash_skip    = 1'b0;
      soft_reset_req = 1'b0;
      cpu_hold       = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      tests_run++;
      if ({splashscreen, reset_sys, reset_cpu, reset_periph, seq_done, seq_state} !==
          {1'b1, 1'b1, 1'b1, 2'b11, 1'b0, 3'd0}) begin
         tests_failed++;
         $display("FAIL reset_values: got %b%b%b %b %b st=%0d, want 111 11 0 st=0",
                  splashscreen, reset_sys, reset_cpu, reset_periph, seq_done, seq_state);
      end
   endtask

   task automatic test_nominal();
      do_reset();
      goto(7);
      tests_run++;
      if (splashscreen !== 1'b1) begin
         tests_failed++;
         $display("FAIL nom_splash_e7: got %b want 1", splashscreen);
      end
      goto(8);
      tests_run++;
      if ({splashscreen, reset_sys, seq_state} !== {1'b0, 1'b1, 3'd1}) begin
         tests_failed++;
         $display("FAIL nom_sysrst_e8: got splash=%b sys=%b st=%0d want 0 1 1",
                  splashscreen, reset_sys, seq_state);
      end
      goto(15);
      tests_run++;
      if (reset_sys !== 1'b1) begin
         tests_failed++;
         $display("FAIL nom_sys_e15: got %b want 1", reset_sys);
      end
      goto(16);
      tests_run++;
      if ({reset_sys, reset_cpu, seq_state} !== {1'b0, 1'b1, 3'd2}) begin
         tests_failed++;
         $display("FAIL nom_cpudly_e16: got sys=%b cpu=%b st=%0d want 0 1 2",
                  reset_sys, reset_cpu, seq_state);
      end
      goto(18);
      tests_run++;
      if (reset_cpu !== 1'b1) begin
         tests_failed++;
         $display("FAIL nom_cpu_e18: got %b want 1", reset_cpu);
      end
      goto(19);
      tests_run++;
      if ({reset_cpu, reset_periph, seq_state} !== {1'b0, 2'b11, 3'd3}) begin
         tests_failed++;
         $display("FAIL nom_periph_e19: got cpu=%b per=%b st=%0d want 0 11 3",
                  reset_cpu, reset_periph, seq_state);
      end
      goto(20);
      tests_run++;
      if (reset_periph !== 2'b11) begin
         tests_failed++;
         $display("FAIL nom_periph_e20: got %b want 11", reset_periph);
      end
      goto(21);
      tests_run++;
      if ({reset_periph, seq_done} !== {2'b10, 1'b0}) begin
         tests_failed++;
         $display("FAIL nom_periph_e21: got per=%b done=%b want 10 0", reset_periph, seq_done);
      end
      goto(22);
      tests_run++;
      if ({reset_periph, seq_done} !== {2'b10, 1'b0}) begin
         tests_failed++;
         $display("FAIL nom_periph_e22: got per=%b done=%b want 10 0", reset_periph, seq_done);
      end
      goto(23);
      tests_run++;
      if ({reset_periph, seq_done, seq_state} !== {2'b00, 1'b1, 3'd4}) begin
         tests_failed++;
         $display("FAIL nom_run_e23: got per=%b done=%b st=%0d want 00 1 4",
                  reset_periph, seq_done, seq_state);
      end
      goto(28);
      tests_run++;
      if ({splashscreen, reset_sys, reset_cpu, reset_periph, seq_done} !== 6'b000001) begin
         tests_failed++;
         $display("FAIL nom_run_hold_e28: got %b%b%b %b %b want 000 00 1",
                  splashscreen, reset_sys, reset_cpu, reset_periph, seq_done);
      end
   endtask

   task automatic test_skip();
      do_reset();
      goto(2);
      splash_skip = 1'b1;
      goto(3);
      splash_skip = 1'b0;
      tests_run++;
      if ({splashscreen, seq_state} !== {1'b0, 3'd1}) begin
         tests_failed++;
         $display("FAIL skip_e3: got splash=%b st=%0d want 0 1", splashscreen, seq_state);
      end
      goto(10);
      tests_run++;
      if (reset_sys !== 1'b1) begin
         tests_failed++;
         $display("FAIL skip_sys_e10: got %b want 1", reset_sys);
      end
      goto(11);
      tests_run++;
      if (reset_sys !== 1'b0) begin
         tests_failed++;
         $display("FAIL skip_sys_e11: got %b want 0", reset_sys);
      end
   endtask

   // Soft reset during SPLASH must be ignored; with skip also high, skip wins.
   task automatic test_soft_in_splash();
      do_reset();
      goto(1);
      soft_reset_req = 1'b1;
      goto(5);
      tests_run++;
      if ({splashscreen, seq_state} !== {1'b1, 3'd0}) begin
         tests_failed++;
         $display("FAIL soft_splash_e5: got splash=%b st=%0d want 1 0", splashscreen, seq_state);
      end
      splash_skip = 1'b1;
      goto(6);
      splash_skip    = 1'b0;
      soft_reset_req = 1'b0;
      tests_run++;
      if ({splashscreen, reset_sys, seq_state} !== {1'b0, 1'b1, 3'd1}) begin
         tests_failed++;
         $display("FAIL soft_skip_e6: got splash=%b sys=%b st=%0d want 0 1 1",
                  splashscreen, reset_sys, seq_state);
      end
      goto(14);
      tests_run++;
      if (reset_sys !== 1'b0) begin
         tests_failed++;
         $display("FAIL soft_skip_sys_e14: got %b want 0", reset_sys);
      end
   endtask

   // cpu_hold sampled high on edges 18..26.
   task automatic test_hold();
      do_reset();
      goto(17);
      cpu_hold = 1'b1;
      goto(19);
      tests_run++;
      if ({reset_cpu, seq_state} !== {1'b1, 3'd2}) begin
         tests_failed++;
         $display("FAIL hold_e19: got cpu=%b st=%0d want 1 2", reset_cpu, seq_state);
      end
      goto(26);
      cpu_hold = 1'b0;
      tests_run++;
      if (reset_cpu !== 1'b1) begin
         tests_failed++;
         $display("FAIL hold_e26: got %b want 1", reset_cpu);
      end
      goto(27);
      tests_run++;
      if (reset_cpu !== 1'b1) begin
         tests_failed++;
         $display("FAIL hold_e27: got %b want 1", reset_cpu);
      end
      goto(28);
      tests_run++;
      if ({reset_cpu, seq_state} !== {1'b0, 3'd3}) begin
         tests_failed++;
         $display("FAIL hold_e28: got cpu=%b st=%0d want 0 3", reset_cpu, seq_state);
      end
   endtask

   task automatic test_soft_reset_run();
      do_reset();
      goto(29);
      tests_run++;
      if (seq_done !== 1'b1) begin
         tests_failed++;
         $display("FAIL soft_pre_e29: got done=%b want 1", seq_done);
      end
      soft_reset_req = 1'b1;
      goto(30);
      soft_reset_req = 1'b0;
      tests_run++;
      if ({splashscreen, reset_sys, reset_cpu, reset_periph, seq_done, seq_state} !==
          {1'b0, 1'b1, 1'b1, 2'b11, 1'b0, 3'd1}) begin
         tests_failed++;
         $display("FAIL soft_run_e30: got %b%b%b %b %b st=%0d want 011 11 0 st=1",
                  splashscreen, reset_sys, reset_cpu, reset_periph, seq_done, seq_state);
      end
      goto(37);
      tests_run++;
      if ({splashscreen, reset_sys} !== 2'b01) begin
         tests_failed++;
         $display("FAIL soft_sys_e37: got splash=%b sys=%b want 0 1", splashscreen, reset_sys);
      end
      goto(38);
      tests_run++;
      if ({splashscreen, reset_sys, seq_state} !== {1'b0, 1'b0, 3'd2}) begin
         tests_failed++;
         $display("FAIL soft_sys_e38: got splash=%b sys=%b st=%0d want 0 0 2",
                  splashscreen, reset_sys, seq_state);
      end
   endtask

   // Request held over edges 30..32 pins SYS_RST; release counts from edge 32.
   task automatic test_soft_pinned();
      do_reset();
      goto(29);
      soft_reset_req = 1'b1;
      goto(32);
      soft_reset_req = 1'b0;
      goto(39);
      tests_run++;
      if ({reset_sys, seq_state} !== {1'b1, 3'd1}) begin
         tests_failed++;
         $display("FAIL pinned_e39: got sys=%b st=%0d want 1 1", reset_sys, seq_state);
      end
      goto(40);
      tests_run++;
      if (reset_sys !== 1'b0) begin
         tests_failed++;
         $display("FAIL pinned_e40: got %b want 0", reset_sys);
      end
   endtask

   task automatic test_sync_reset();
      do_reset();
      goto(21);
      reset = 1'b1;
      goto(22);
      tests_run++;
      if ({splashscreen, reset_sys, reset_cpu, reset_periph, seq_done, seq_state} !==
          {1'b1, 1'b1, 1'b1, 2'b11, 1'b0, 3'd0}) begin
         tests_failed++;
         $display("FAIL sync_reset_e22: got %b%b%b %b %b st=%0d want 111 11 0 st=0",
                  splashscreen, reset_sys, reset_cpu, reset_periph, seq_done, seq_state);
      end
      reset = 1'b0;
      e     = -1;
      goto(7);
      tests_run++;
      if (splashscreen !== 1'b1) begin
         tests_failed++;
         $display("FAIL replay_splash_e7: got %b want 1", splashscreen);
      end
      goto(8);
      tests_run++;
      if (splashscreen !== 1'b0) begin
         tests_failed++;
         $display("FAIL replay_splash_e8: got %b want 0", splashscreen);
      end
      goto(19);
      tests_run++;
      if ({reset_sys, reset_cpu} !== 2'b00) begin
         tests_failed++;
         $display("FAIL replay_cpu_e19: got sys=%b cpu=%b want 0 0", reset_sys, reset_cpu);
      end
      goto(23);
      tests_run++;
      if ({reset_periph, seq_done} !== {2'b00, 1'b1}) begin
         tests_failed++;
         $display("FAIL replay_run_e23: got per=%b done=%b want 00 1", reset_periph, seq_done);
      end
   endtask

   // SPLASH_TICKS=0, NUM_PERIPH=1 instance: SYS_RST 1..9, CPU_DLY 9..12, bit clears at 14.
   task automatic test_corner();
      do_reset();
      goto(0);
      tests_run++;
      if (c_splashscreen !== 1'b1) begin
         tests_failed++;
         $display("FAIL corner_splash_e0: got %b want 1", c_splashscreen);
      end
      goto(1);
      tests_run++;
      if ({c_splashscreen, c_reset_sys, c_seq_state} !== {1'b0, 1'b1, 3'd1}) begin
         tests_failed++;
         $display("FAIL corner_splash_e1: got splash=%b sys=%b st=%0d want 0 1 1",
                  c_splashscreen, c_reset_sys, c_seq_state);
      end
      goto(9);
      tests_run++;
      if ({c_reset_sys, c_reset_cpu} !== 2'b01) begin
         tests_failed++;
         $display("FAIL corner_sys_e9: got sys=%b cpu=%b want 0 1", c_reset_sys, c_reset_cpu);
      end
      goto(12);
      tests_run++;
      if ({c_reset_cpu, c_reset_periph} !== 2'b01) begin
         tests_failed++;
         $display("FAIL corner_cpu_e12: got cpu=%b per=%b want 0 1", c_reset_cpu, c_reset_periph);
      end
      goto(13);
      tests_run++;
      if ({c_reset_periph, c_seq_done} !== 2'b10) begin
         tests_failed++;
         $display("FAIL corner_e13: got per=%b done=%b want 1 0", c_reset_periph, c_seq_done);
      end
      goto(14);
      tests_run++;
      if ({c_reset_periph, c_seq_done, c_seq_state} !== {1'b0, 1'b1, 3'd4}) begin
         tests_failed++;
         $display("FAIL corner_run_e14: got per=%b done=%b st=%0d want 0 1 4",
                  c_reset_periph, c_seq_done, c_seq_state);
      end
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      e            = 0;
      test_reset();
      test_nominal();
      test_skip();
      test_soft_in_splash();
      test_hold();
      test_soft_reset_run();
      test_soft_pinned();
      test_sync_reset();
      test_corner();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
